// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan_sequencer channel scanner.
// Channel count, index width, FSM state type and the lowest-set-bit search.
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index of the lowest enabled channel; 0 when the mask is empty.
    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r = CH_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Combinational next-channel search over the latched enable mask.
// Returns the next higher enabled index, or the lowest one with wrap set.
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    output logic [CH_W-1:0]   nxt,
    output logic              wrap
);

    // Descending loop so the closest higher channel is the last one written.
    always_comb begin
        nxt  = lowest_set(mask);
        wrap = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt  = CH_W'(i);
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Sequential channel scanner producing the 3-bit select for a 3-to-8 decoder.
// Define SCAN_SEQUENCER_ONEHOT_EN to add a registered onehot[7:0] output.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  ch_mask,
    output logic [CH_W-1:0]    sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic               scan_wrap
`ifdef SCAN_SEQUENCER_ONEHOT_EN
    ,
    output logic [NUM_CH-1:0]  onehot
`endif
);

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [NUM_CH-1:0]  mask_q;
    logic               mode_q;
    logic [CH_W-1:0]    next_sel;
    logic               next_wrap;
    logic [CH_W-1:0]    first_sel;

    assign first_sel = lowest_set(ch_mask);

    scan_next_ch u_next_ch (
        .mask (mask_q),
        .cur  (sel),
        .nxt  (next_sel),
        .wrap (next_wrap)
    );

    // Stop outranks both a pending start in IDLE and a same-cycle advance in SCAN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            scan_wrap <= 1'b0;
            cnt       <= '0;
            dwell_q   <= '0;
            mask_q    <= '0;
            mode_q    <= 1'b0;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
            onehot    <= '0;
`endif
        end else begin
            done      <= 1'b0;
            scan_wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (ch_mask != '0) begin
                            state     <= SCAN;
                            mask_q    <= ch_mask;
                            dwell_q   <= dwell;
                            mode_q    <= mode_cont;
                            sel       <= first_sel;
                            sel_valid <= 1'b1;
                            busy      <= 1'b1;
                            cnt       <= dwell;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
                            onehot    <= ch_onehot(first_sel);
`endif
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (stop) begin
                        state     <= IDLE;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
                        onehot    <= '0;
`endif
                    end else if (cnt != '0) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else if (!next_wrap || mode_q) begin
                        // Zero-bubble advance; a continuous lap restart flags the wrap.
                        sel       <= next_sel;
                        cnt       <= dwell_q;
                        scan_wrap <= next_wrap;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
                        onehot    <= ch_onehot(next_sel);
`endif
                    end else begin
                        state     <= IDLE;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        scan_wrap <= 1'b1;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
                        onehot    <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: a lap-plan reference model queues the
// expected per-cycle outputs, and a negedge monitor pops and compares them.
module tb_scan_sequencer;

    typedef struct packed {
        logic [2:0] sel;
        logic       valid;
        logic       busy;
        logic       done;
        logic       wrap;
        logic [7:0] oh;
    } rec_t;

    typedef struct packed {
        logic [2:0] ch;
        logic       wrap;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [7:0] ch_mask = 8'd0;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       done;
    logic       scan_wrap;
    logic [7:0] oh_act;

    int tests = 0;
    int fails = 0;

    rec_t  sb[$];
    step_t plan[$];

    logic       m_busy = 1'b0;
    logic [2:0] m_sel = 3'd0;
    logic [7:0] m_mask = 8'd0;
    logic [7:0] m_dwell = 8'd0;
    logic       m_cont = 1'b0;

`ifdef SCAN_SEQUENCER_ONEHOT_EN
    logic [7:0] onehot;
    assign oh_act = onehot;
`else
    assign oh_act = 8'h00;
`endif

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .dwell     (dwell),
        .ch_mask   (ch_mask),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done),
        .scan_wrap (scan_wrap)
`ifdef SCAN_SEQUENCER_ONEHOT_EN
        ,
        .onehot    (onehot)
`endif
    );

    always #5 clk = ~clk;

    // One lap: every enabled channel in ascending order, dwell+1 entries each.
    task automatic build_lap(input logic wrap_first);
        logic first;
        first = wrap_first;
        for (int ch = 0; ch < 8; ch++) begin
            if (m_mask[ch]) begin
                for (int k = 0; k <= int'(m_dwell); k++) begin
                    plan.push_back('{ch: 3'(ch), wrap: first});
                    first = 1'b0;
                end
            end
        end
    endtask

    // Reference model: at each edge decide what the next cycle must show.
    always @(posedge clk) begin
        rec_t  r;
        step_t s;
        if (rst_n) begin
            r = '0;
            if (!m_busy) begin
                if (start && !stop) begin
                    if (ch_mask != 8'h00) begin
                        m_mask  = ch_mask;
                        m_dwell = dwell;
                        m_cont  = mode_cont;
                        plan.delete();
                        build_lap(1'b0);
                        m_busy = 1'b1;
                    end else begin
                        r.done = 1'b1;
                    end
                end
            end else if (stop) begin
                m_busy = 1'b0;
                plan.delete();
            end else if (plan.size() == 0) begin
                if (m_cont) begin
                    build_lap(1'b1);
                end else begin
                    m_busy = 1'b0;
                    r.done = 1'b1;
                    r.wrap = 1'b1;
                end
            end
            if (m_busy) begin
                s      = plan.pop_front();
                m_sel  = s.ch;
                r.wrap = s.wrap;
                r.valid = 1'b1;
                r.busy  = 1'b1;
            end
            r.sel = m_sel;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
            r.oh = r.valid ? (8'h01 << m_sel) : 8'h00;
`endif
            sb.push_back(r);
        end
    end

    task automatic checkOutput(input string name, input rec_t act, input rec_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s @%0t: got sel=%0d v=%b busy=%b done=%b wrap=%b oh=%h, want sel=%0d v=%b busy=%b done=%b wrap=%b oh=%h",
                     name, $time, act.sel, act.valid, act.busy, act.done, act.wrap, act.oh,
                     exp.sel, exp.valid, exp.busy, exp.done, exp.wrap, exp.oh);
        end
    endtask

    // Monitor: one expected record per clocked cycle out of reset.
    always @(negedge clk) begin
        rec_t act;
        rec_t exp;
        if (rst_n && sb.size() > 0) begin
            exp = sb.pop_front();
            act = '{sel: sel, valid: sel_valid, busy: busy, done: done, wrap: scan_wrap, oh: oh_act};
            checkOutput("cycle", act, exp);
        end
    end

    task automatic applyStimulus(input logic st, input logic sp, input logic md,
                                 input logic [7:0] dw, input logic [7:0] mk);
        start     = st;
        stop      = sp;
        mode_cont = md;
        dwell     = dw;
        ch_mask   = mk;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("[TB] FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, limit);
        end
    endtask

    // Asynchronous reset landing mid-cycle; outputs must clear before any edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset",
                    '{sel: sel, valid: sel_valid, busy: busy, done: done, wrap: scan_wrap, oh: oh_act},
                    rec_t'(0));
        sb.delete();
        plan.delete();
        m_busy = 1'b0;
        m_sel  = 3'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset",
                    '{sel: sel, valid: sel_valid, busy: busy, done: done, wrap: scan_wrap, oh: oh_act},
                    rec_t'(0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd2, 8'b0010_0101);
        idle(12);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'd0, 8'h81);
        idle(9);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'h00);
        idle(2);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
        idle(3);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'd1, 8'h0F);
        idle(3);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 8'b0010_0101);
        idle(5);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd3, 8'b0010_0101);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 8'b0010_0101);
        wait_idle(40);
        idle(2);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 8'h0A);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd5, 8'hFF);
        wait_idle(40);
        idle(2);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'd1, 8'h10);
        idle(7);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 8'h6C);
        idle(4);
        async_reset();
        idle(3);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 8'h10);
        wait_idle(300);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom % 4) == 0;
            stop      = ($urandom % 40) == 0;
            mode_cont = 1'($urandom % 2);
            dwell     = 8'($urandom % 4);
            ch_mask   = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stop  = 1'b1;
        idle(2);
        stop = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Sequential channel scanner that generates the 3-bit select consumed by the 3-to-8 one-hot decoder stage directly downstream.
- Steps through a latched 8-bit channel-enable mask and holds each enabled channel for a programmable dwell time.
- Supports single-shot and continuous scans, abort, and lap-boundary signalling.
- Used for multiplexed LED/display/strobe scanning.

Parameters:
- DWELL_W, 8, width of the dwell count; each channel is held for dwell+1 cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a scan; sampled only in IDLE
- stop  input  1  abort the scan; takes effect at the next clock edge
- mode_cont  input  1  latched at start; 1 = continuous, 0 = single-shot
- dwell  input  DWELL_W  latched at start; hold time minus 1
- ch_mask  input  8  latched at start; bit i enables channel i
- sel  output  3  current channel index to the decoder
- sel_valid  output  1  sel is an active channel
- busy  output  1  FSM is in SCAN
- done  output  1  one-cycle pulse at single-shot completion
- scan_wrap  output  1  one-cycle pulse at the first cycle after a lap completes

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: FSM=IDLE, sel=0, sel_valid=0, busy=0, done=0, scan_wrap=0, dwell counter=0, latched mask=0, latched mode=0.
- FSM states: IDLE, SCAN.
- IDLE, start=1, stop=0, ch_mask!=0:
  - latch mask, dwell and mode;
  - next cycle: sel = lowest enabled index, sel_valid=1, busy=1, counter=dwell.
- IDLE, start=1, ch_mask==0: done pulses next cycle; FSM stays in IDLE.
- IDLE, start=1 and stop=1 in the same cycle: stop wins; nothing happens.
- SCAN, stepping:
  - counter decrements each cycle;
  - when counter==0, the next edge advances sel to the next higher enabled index and reloads the counter to dwell.
- SCAN, lap end (no higher enabled index exists):
  - single-shot: next cycle sel_valid=0, busy=0, done=1, scan_wrap=1; FSM returns to IDLE; sel keeps its last value.
  - continuous: next cycle sel = lowest enabled index, scan_wrap=1; scan continues.
- Single enabled channel: that index is held continuously; scan_wrap pulses every dwell+1 cycles.
- stop in SCAN: next edge sets IDLE, sel_valid=0, busy=0; no done, no scan_wrap. stop has priority over a same-cycle advance.
- start while busy is ignored. Changes to ch_mask, dwell or mode_cont mid-scan are ignored until the next start.
- Next-channel search is combinational over the 8 latched bits; advances are zero-bubble, so a new sel is valid on the same edge the old dwell ends.
- dwell=0: each channel is held for 1 cycle. Maximum dwell: 2^DWELL_W cycles per channel.
- rst_n asserted mid-scan: all outputs go immediately to their reset values.
- All outputs are registered.

Optional Feature:
- Macro: SCAN_SEQUENCER_ONEHOT_EN.
- Defined: adds output port onehot[7:0] = (1 << sel) when sel_valid=1, else 8'h00. It is registered and cycle-aligned with sel, so the downstream decoder can be bypassed.
- Undefined: port absent; sel is the only channel output.

Decomposition:
- Package scan_pkg holds:
  - NUM_CH=8, CH_W=3;
  - state enum {IDLE, SCAN};
  - function lowest_set(mask).
- One sub-module, scan_next_ch: combinational; inputs latched mask and current index; outputs next higher enabled index plus a wrap flag.

Test Plan:
- Single-shot timing: mask=8'b0010_0101, dwell=2, mode_cont=0, start at cycle 0 -> sel=0 in cycles 1-3, sel=2 in cycles 4-6, sel=5 in cycles 7-9; cycle 10: sel_valid=0, busy=0, done=1, scan_wrap=1.
- Continuous mode: mask=8'h81, dwell=0, mode_cont=1 -> sel alternates 0,7,0,7,…; scan_wrap=1 in every cycle where sel returns to 0; done never asserted.
- Empty mask: mask=8'h00, start=1 -> busy stays 0, sel_valid stays 0, done=1 for exactly one cycle on the next edge.
- Abort: stop asserted while sel=2 mid-dwell -> next cycle busy=0, sel_valid=0, done=0, scan_wrap=0; a new start afterwards begins at the lowest enabled channel.
- Ignored inputs: during a scan, change ch_mask to 8'hFF and pulse start -> sequence is unchanged. Async reset mid-scan -> all outputs 0 immediately, before the next clock edge.
- Maximum dwell: dwell=8'hFF, mask=8'h10, single-shot -> sel=4 for exactly 256 cycles, then done=1. With SCAN_SEQUENCER_ONEHOT_EN defined, onehot=8'h10 throughout those 256 cycles.
